// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer and program-memory arbiter for the 8-bit accumulator CPU.
// Gates CPU updates, stops on a pc breakpoint, muxes loader writes and counts retired cycles.
module cpu_run_ctrl #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               step_req,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  input  logic               ld_valid,
  input  logic [PC_W-1:0]    ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  output logic               cpu_en,
  output logic               cpu_rst,
  output logic               mem_we,
  output logic [PC_W-1:0]    mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               halted,
  output logic               bp_hit,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_LOAD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             skip_bp, skip_bp_d;
  logic             bp_hit_d, cpu_rst_d;
  logic             bp_stop;
  logic [CNT_W-1:0] retired_d;

  // skip_bp lets a resume from the breakpoint pc execute that instruction once.
  assign bp_stop   = bp_en && (pc == bp_addr) && !skip_bp;
  assign cpu_en    = !reset && (((state_q == S_RUN) && !bp_stop) || (state_q == S_STEP));
  assign ld_ready  = !reset && ((state_q == S_HALT) || (state_q == S_LOAD));
  assign mem_we    = ld_valid && ld_ready;
  assign mem_addr  = mem_we ? ld_addr : pc;
  assign mem_wdata = ld_data;
  assign halted    = (state_q == S_HALT);
  assign state     = state_q;

  // NOTE: every always_comb target gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    skip_bp_d = skip_bp;
    bp_hit_d  = bp_hit;
    cpu_rst_d = 1'b0;
    case (state_q)
      S_HALT: begin
        if (ld_valid) begin
          state_d = S_LOAD;
        end else if (run_req) begin
          state_d   = S_RUN;
          skip_bp_d = 1'b1;
          bp_hit_d  = 1'b0;
        end else if (step_req) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
        end
      end
      S_RUN: begin
        skip_bp_d = 1'b0;
        if (bp_stop) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end else if (halt_req) begin
          state_d = S_HALT;
        end
      end
      S_STEP: state_d = S_HALT;
      S_LOAD: begin
        if (!ld_valid) begin
          state_d   = S_HALT;
          cpu_rst_d = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // The counter reads 0 during the cpu_rst cycle; cpu_en is never high in LOAD, so no conflict.
  always_comb begin
    retired_d = retired;
    if (cpu_rst_d) begin
      retired_d = '0;
    end else if (cpu_en) begin
      retired_d = retired + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HALT;
      skip_bp <= 1'b0;
      bp_hit  <= 1'b0;
      cpu_rst <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      skip_bp <= skip_bp_d;
      bp_hit  <= bp_hit_d;
      cpu_rst <= cpu_rst_d;
      retired <= retired_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl with a tiny pc model standing in for the CPU.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_req, halt_req, step_req, bp_en;
  logic [3:0]  bp_addr, pc, ld_addr, mem_addr;
  logic        ld_valid;
  logic [7:0]  ld_data, mem_wdata;
  logic        ld_ready, cpu_en, cpu_rst, mem_we, halted, bp_hit;
  logic [1:0]  state;
  logic [15:0] retired;

  int n_cmp = 0;
  int n_bad = 0;
  int en_count = 0;

  cpu_run_ctrl dut (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .cpu_en(cpu_en), .cpu_rst(cpu_rst), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .halted(halted),
    .bp_hit(bp_hit), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // Stand-in CPU: pc advances on each enabled cycle and clears on cpu_rst.
  always @(posedge clk or posedge reset) begin
    if (reset)        pc <= '0;
    else if (cpu_rst) pc <= '0;
    else if (cpu_en)  pc <= pc + 4'd1;
  end

  always @(posedge clk) if (cpu_en) en_count <= en_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] ld_tbl [4];
    int n;
    int en_base;
    ld_tbl[0] = 8'hA5; ld_tbl[1] = 8'h3C; ld_tbl[2] = 8'hFF; ld_tbl[3] = 8'h00;

    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    bp_en = 1'b0; bp_addr = 4'd0; ld_valid = 1'b1; ld_addr = 4'd9; ld_data = 8'h00;

    // Reset state, with a loader request that must be blocked while reset is high.
    #12;
    check("rst_state",   state, 0);
    check("rst_halted",  halted, 1);
    check("rst_cpu_en",  cpu_en, 0);
    check("rst_ld_rdy",  ld_ready, 0);
    check("rst_mem_we",  mem_we, 0);
    check("rst_retired", retired, 0);
    check("rst_bp_hit",  bp_hit, 0);
    check("rst_cpu_rst", cpu_rst, 0);
    ld_valid = 1'b0;
    @(negedge clk) reset = 1'b0;

    // Test 1: run, six executed cycles, halt.
    step_clk();
    halt_req = 1'b1;
    step_clk();
    halt_req = 1'b0;
    check("t1_halt_ignored", state, 0);
    run_req = 1'b1;
    #1 check("t1_latency", cpu_en, 0);
    step_clk();
    run_req = 1'b0;
    check("t1_run_state", state, 1);
    check("t1_run_en", cpu_en, 1);
    repeat (5) step_clk();
    halt_req = 1'b1;
    #1 check("t1_last_exec", cpu_en, 1);
    step_clk();
    halt_req = 1'b0;
    check("t1_halt_en", cpu_en, 0);
    check("t1_halted", halted, 1);
    check("t1_retired", retired, 6);

    // Test 2: breakpoint at pc=5, halt_req coinciding with the stop, then resume past it.
    pulse_reset();
    bp_en = 1'b1; bp_addr = 4'd5;
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    n = 0;
    while (cpu_en && n < 20) begin
      step_clk();
      n++;
    end
    check("t2_bp_timeout", n < 20, 1);
    halt_req = 1'b1;
    #1;
    check("t2_stop_pc", pc, 5);
    check("t2_stop_en", cpu_en, 0);
    check("t2_stop_state", state, 1);
    step_clk();
    halt_req = 1'b0;
    check("t2_halted", halted, 1);
    check("t2_bp_hit", bp_hit, 1);
    check("t2_retired", retired, 5);
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    check("t2_resume_en", cpu_en, 1);
    check("t2_hit_clear", bp_hit, 0);
    step_clk();
    check("t2_pc_past", pc, 6);
    check("t2_run_on", cpu_en, 1);
    halt_req = 1'b1;
    step_clk();
    halt_req = 1'b0;
    bp_en = 1'b0;
    check("t2_halt_again", halted, 1);

    // Test 3: three single steps.
    pulse_reset();
    en_base = en_count;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      step_clk();
      step_req = 1'b0;
      check("t3_step_state", state, 2);
      check("t3_step_en", cpu_en, 1);
      step_clk();
      check("t3_back_halt", state, 0);
      check("t3_en_off", cpu_en, 0);
      step_clk();
    end
    check("t3_pulses", en_count - en_base, 3);
    check("t3_retired", retired, 3);
    check("t3_pc", pc, 3);

    // Test 4: four loader writes, run_req ignored in LOAD, exit pulses cpu_rst.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 4'(i);
      ld_data  = ld_tbl[i];
      run_req  = (i == 1);
      #1;
      check("t4_we", mem_we, 1);
      check("t4_addr", mem_addr, i);
      check("t4_data", mem_wdata, ld_tbl[i]);
      step_clk();
      check("t4_state", state, 3);
    end
    run_req  = 1'b0;
    ld_valid = 1'b0;
    #1;
    check("t4_we_off", mem_we, 0);
    check("t4_ready", ld_ready, 1);
    step_clk();
    check("t4_exit_state", state, 0);
    check("t4_cpu_rst", cpu_rst, 1);
    check("t4_retired", retired, 0);
    step_clk();
    check("t4_rst_once", cpu_rst, 0);
    check("t4_retired_hold", retired, 0);
    check("t4_pc_zero", pc, 0);

    // Test 5: loader shut out while running.
    pulse_reset();
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 8'h11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_ready", ld_ready, 0);
      check("t5_we", mem_we, 0);
      check("t5_addr", mem_addr, pc);
      check("t5_state", state, 1);
      step_clk();
    end
    ld_valid = 1'b0;

    // Test 6: asynchronous reset in the middle of a RUN cycle.
    check("t6_pre_en", cpu_en, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_en", cpu_en, 0);
    check("t6_state", state, 0);
    check("t6_retired", retired, 0);
    check("t6_bp_hit", bp_hit, 0);
    check("t6_halted", halted, 1);
    #1 reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
